regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter NUM_RD, default 2, number of read ports.
REQ-004 Parameter NUM_WR, default 2, number of write ports.
REQ-005 Parameter BYPASS, default 1; 1 forwards same-cycle write data to reads.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at slice i.
REQ-009 rd_data  out  NUM_RD*DATA_W  read data, combinational, port i at slice i.
REQ-010 rd_busy  out  NUM_RD  scoreboard pending bit of each read address.
REQ-011 wr_en  in  NUM_WR  write enables.
REQ-012 wr_addr  in  NUM_WR*ADDR_W  write addresses.
REQ-013 wr_data  in  NUM_WR*DATA_W  write data.
REQ-014 sb_set  in  1  marks sb_addr pending.
REQ-015 sb_addr  in  ADDR_W  scoreboard set address.
REQ-016 clr_req  in  1  requests a full zero-clear of the array.
REQ-017 ready  out  1  high when the array is initialised and accepting writes.

Function
REQ-018 Register 0 reads as 0 on every port; writes and sb_set to address 0 are dropped.
REQ-019 Write on wr_en[j] updates regmem[wr_addr[j]] at the next rising edge; read latency is 0 cycles (combinational).
REQ-020 Two or more write ports targeting the same address in one cycle: the highest-indexed port wins.
REQ-021 BYPASS=1: a read matching an enabled write address in the same cycle returns that write's data (winning port per REQ-020); BYPASS=0: returns the old array value.
REQ-022 Scoreboard: DEPTH pending bits; sb_set sets bit sb_addr at the edge; any accepted write clears the bit of its address.
REQ-023 sb_set and a write to the same address in one cycle: the bit ends set.
REQ-024 rd_busy[i] = pending bit of rd_addr[i], combinational; it does not reflect same-cycle writes or sb_set.
REQ-025 Clear FSM states: CLEAR, READY.
REQ-026 CLEAR: writes 0 to address cnt each cycle, cnt counts 1..DEPTH-1, ready=0, all wr_en and sb_set ignored, rd_data forced to 0.
REQ-027 CLEAR -> READY in the cycle after cnt = DEPTH-1 is written; clear therefore takes DEPTH-1 cycles.
REQ-028 READY -> CLEAR on clr_req=1; cnt reloads to 1; pending bits all clear at that edge; same-cycle writes are dropped.
REQ-029 clr_req held high in CLEAR has no effect (the sequence does not restart).

Reset
REQ-030 rst_n low: state=CLEAR, cnt=1, all pending bits 0, ready=0, rd_busy=0, rd_data=0, independent of clk.
REQ-031 Array contents are not reset directly; they are zeroed by the CLEAR sequence after rst_n rises.
REQ-032 rst_n asserted mid-CLEAR or mid-write aborts the operation; the sequence restarts from cnt=1 after release.

Structure
REQ-033 Shared package regfile_pkg holds the FSM state encoding and the default values of DATA_W/ADDR_W.
REQ-034 Clear FSM and counter live in sub-module regfile_clear_fsm (outputs ready, clr_we, clr_addr); the array, write arbitration, bypass and scoreboard stay in regfile_mp.

Verification
REQ-035 Release rst_n, hold wr_en=0 -> ready rises exactly 31 cycles later; every rd_addr reads 0.
REQ-036 READY; wr_en=2'b11, both wr_addr=5, wr_data={0xAAAA0000,0x00005555} (port1 slice=0xAAAA0000) -> rd_addr=5 returns 0xAAAA0000 in the same cycle (BYPASS=1) and after the edge.
REQ-037 READY; write 0xDEADBEEF to address 0 -> reads of address 0 return 0; rd_busy for address 0 stays 0 after sb_set to 0.
REQ-038 sb_set at sb_addr=7 -> rd_busy=1 for rd_addr=7 next cycle; write to 7 -> rd_busy=0 next cycle; sb_set and write to 7 in one cycle -> rd_busy=1.
REQ-039 Write 0x12345678 to 9, pulse clr_req -> ready=0 next cycle, writes ignored for 31 cycles, address 9 reads 0 after ready=1.
REQ-040 Assert rst_n low at cycle 10 of CLEAR -> ready and rd_busy=0 immediately; after release ready rises 31 cycles later.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and default sizes for the multi-port register file
// Contents: clear FSM state encoding, default DATA_W / ADDR_W.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } clr_state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// rtl/regfile_clear_fsm.sv - zero-clear sequencer for the register array
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   clr_req          request a full clear (honoured only in READY)
//   ready            array initialised and accepting writes
//   clr_we, clr_addr zero-write strobe and address driven during CLEAR
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    clr_state_e        state;
    clr_state_e        state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
            cnt   <= ADDR_W'(1);
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Address 0 is hard-wired to zero on reads, so the sweep starts at 1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready     = 1'b0;
        clr_we    = 1'b0;
        clr_addr  = cnt;
        unique case (state)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (cnt == '1) begin
                    state_nxt = ST_READY;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_READY: begin
                ready = 1'b1;
                if (clr_req) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = ADDR_W'(1);
                end
            end
            default: begin
                state_nxt = ST_CLEAR;
                cnt_nxt   = ADDR_W'(1);
            end
        endcase
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with write bypass and pending scoreboard
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rd_addr / rd_data          NUM_RD combinational read ports (port i at slice i)
//   rd_busy                    pending bit of each read address
//   wr_en / wr_addr / wr_data  NUM_WR write ports, highest index wins on collision
//   sb_set / sb_addr           mark a register pending
//   clr_req                    start a full zero-clear
//   ready                      array initialised and accepting writes
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_addr,
    input  logic                     clr_req,
    output logic                     ready
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regmem [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pending_nxt;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic [NUM_WR-1:0] wr_ok;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;

    regfile_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // A write is accepted only in READY and not in the cycle that starts a clear.
    always_comb begin
        wr_ok = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            wr_ok[j] = ready && !clr_req && wr_en[j] &&
                       (wr_addr[j*ADDR_W +: ADDR_W] != '0);
        end
    end

    // Later loop iterations override earlier ones, so the highest port wins.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            regmem[clr_addr] <= '0;
        end
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_ok[j]) begin
                regmem[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
            end
        end
    end

    // Set is applied after the write clears so a same-cycle set survives.
    always_comb begin
        pending_nxt = pending;
        if (ready && clr_req) begin
            pending_nxt = '0;
        end else if (ready) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_ok[j]) begin
                    pending_nxt[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
                end
            end
            if (sb_set && (sb_addr != '0)) begin
                pending_nxt[sb_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        rv      = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra = rd_addr[i*ADDR_W +: ADDR_W];
            rv = regmem[ra];
            if (BYPASS != 0) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_ok[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ra)) begin
                        rv = wr_data[j*DATA_W +: DATA_W];
                    end
                end
            end
            if ((ra == '0) || !ready) begin
                rv = '0;
            end
            rd_data[i*DATA_W +: DATA_W] = rv;
            rd_busy[i]                  = pending[ra];
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp with an expected-value queue
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int NW    = 2;
    localparam int DEPTH = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic [NW-1:0]    wr_en = '0;
    logic [NW*AW-1:0] wr_addr = '0;
    logic [NW*DW-1:0] wr_data = '0;
    logic             sb_set = 1'b0;
    logic [AW-1:0]    sb_addr = '0;
    logic             clr_req = 1'b0;
    logic             ready;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_busy (rd_busy),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .sb_set  (sb_set),
        .sb_addr (sb_addr),
        .clr_req (clr_req),
        .ready   (ready)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] mdl [DEPTH];
    logic [DEPTH-1:0] mpend = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] got);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_val("queue_underflow", got, 32'hxxxx_xxxx);
        end else begin
            e = exp_q.pop_front();
            check_val(e.tag, got, e.val);
        end
    endtask

    function automatic logic [31:0] rdp(input int i);
        return rd_data[i*DW +: DW];
    endfunction

    // Expected read value with same-cycle forwarding of the driven writes.
    function automatic logic [31:0] exp_rd(input logic [AW-1:0] a);
        logic [31:0] v;
        if (a == '0) return 32'h0;
        v = mdl[a];
        for (int j = 0; j < NW; j++) begin
            if (wr_en[j] && wr_addr[j*AW +: AW] == a) v = wr_data[j*DW +: DW];
        end
        return v;
    endfunction

    task automatic model_commit();
        logic [AW-1:0] a;
        for (int j = 0; j < NW; j++) begin
            a = wr_addr[j*AW +: AW];
            if (wr_en[j] && a != '0) begin
                mdl[a]   = wr_data[j*DW +: DW];
                mpend[a] = 1'b0;
            end
        end
        if (sb_set && sb_addr != '0) mpend[sb_addr] = 1'b1;
    endtask

    task automatic model_zero();
        for (int k = 0; k < DEPTH; k++) mdl[k] = 32'h0;
        mpend = '0;
    endtask

    task automatic idle();
        wr_en   = '0;
        sb_set  = 1'b0;
        clr_req = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic wait_ready(input string tag, input int exp_cycles);
        int n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        idle();
        push_exp(tag, 32'(exp_cycles));
        pop_check(32'(n));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_zero();

        // Reset state
        #3;
        push_exp("rst_ready", 32'h0);
        push_exp("rst_busy", 32'h0);
        push_exp("rst_rd0", 32'h0);
        pop_check(32'(ready));
        pop_check(32'(rd_busy));
        pop_check(rdp(0));

        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("init_clear_cycles", 31);

        // Every address reads zero after the initial clear
        for (int a = 0; a < DEPTH; a += 2) begin
            rd_addr = {AW'(a + 1), AW'(a)};
            push_exp($sformatf("init_rd_%0d", a), 32'h0);
            push_exp($sformatf("init_rd_%0d", a + 1), 32'h0);
            #1;
            pop_check(rdp(0));
            pop_check(rdp(1));
            @(negedge clk);
        end

        // Colliding writes: port 1 wins, forwarded and stored
        wr_en   = 2'b11;
        wr_addr = {5'd5, 5'd5};
        wr_data = {32'hAAAA0000, 32'h00005555};
        rd_addr = {5'd5, 5'd5};
        push_exp("collide_byp_p0", 32'hAAAA0000);
        push_exp("collide_byp_p1", 32'hAAAA0000);
        #1;
        pop_check(rdp(0));
        pop_check(rdp(1));
        step();
        idle();
        push_exp("collide_stored", 32'hAAAA0000);
        #1;
        pop_check(rdp(0));
        @(negedge clk);

        // Register 0 is read-only zero and never pending
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd0};
        wr_data = {32'h0, 32'hDEADBEEF};
        sb_set  = 1'b1;
        sb_addr = 5'd0;
        rd_addr = {5'd0, 5'd0};
        push_exp("r0_same_cycle", 32'h0);
        #1;
        pop_check(rdp(0));
        step();
        idle();
        push_exp("r0_after", 32'h0);
        push_exp("r0_busy", 32'h0);
        #1;
        pop_check(rdp(1));
        pop_check(32'(rd_busy));
        @(negedge clk);

        // Scoreboard set / clear / set-wins
        rd_addr = {5'd7, 5'd7};
        sb_set  = 1'b1;
        sb_addr = 5'd7;
        push_exp("sb_set_same_cycle", 32'h0);
        #1;
        pop_check(32'(rd_busy[0]));
        step();
        idle();
        push_exp("sb_set_next", 32'h1);
        #1;
        pop_check(32'(rd_busy[0]));
        @(negedge clk);
        wr_en   = 2'b10;
        wr_addr = {5'd7, 5'd0};
        wr_data = {32'h77777777, 32'h0};
        push_exp("sb_write_same_cycle", 32'h1);
        #1;
        pop_check(32'(rd_busy[1]));
        step();
        idle();
        push_exp("sb_write_clears", 32'h0);
        #1;
        pop_check(32'(rd_busy[0]));
        @(negedge clk);
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd7};
        wr_data = {32'h0, 32'h07070707};
        sb_set  = 1'b1;
        sb_addr = 5'd7;
        step();
        idle();
        push_exp("sb_set_and_write", 32'h1);
        push_exp("sb_set_and_write_data", 32'h07070707);
        #1;
        pop_check(32'(rd_busy[0]));
        pop_check(rdp(1));
        @(negedge clk);

        // Asynchronous reset while READY with a pending bit set
        rst_n = 1'b0;
        #1;
        push_exp("async_rst_ready", 32'h0);
        push_exp("async_rst_busy", 32'h0);
        push_exp("async_rst_rd", 32'h0);
        pop_check(32'(ready));
        pop_check(32'(rd_busy));
        pop_check(rdp(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_zero();
        wait_ready("async_rst_clear_cycles", 31);

        // Random traffic with collisions, bypass and scoreboard activity
        for (int it = 0; it < 24; it++) begin
            wr_en   = NW'($urandom_range(0, 3));
            wr_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            wr_data = {$urandom(), $urandom()};
            rd_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            sb_set  = 1'($urandom_range(0, 1));
            sb_addr = AW'($urandom_range(0, 7));
            push_exp($sformatf("rnd%0d_rd0", it), exp_rd(rd_addr[0 +: AW]));
            push_exp($sformatf("rnd%0d_rd1", it), exp_rd(rd_addr[AW +: AW]));
            push_exp($sformatf("rnd%0d_busy0", it), 32'(mpend[rd_addr[0 +: AW]]));
            push_exp($sformatf("rnd%0d_busy1", it), 32'(mpend[rd_addr[AW +: AW]]));
            #1;
            pop_check(rdp(0));
            pop_check(rdp(1));
            pop_check(32'(rd_busy[0]));
            pop_check(32'(rd_busy[1]));
            step();
        end
        idle();

        // Clear request wipes data and pending bits; writes ignored meanwhile
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd9};
        wr_data = {32'h0, 32'h12345678};
        step();
        idle();
        rd_addr = {5'd10, 5'd9};
        push_exp("pre_clr_rd9", 32'h12345678);
        #1;
        pop_check(rdp(0));
        @(negedge clk);
        clr_req = 1'b1;
        wr_en   = 2'b10;
        wr_addr = {5'd10, 5'd0};
        wr_data = {32'h0BAD0BAD, 32'h0};
        @(posedge clk);
        #1;
        push_exp("clr_ready_low", 32'h0);
        pop_check(32'(ready));
        clr_req = 1'b0;
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd9};
        wr_data = {32'h0, 32'hFFFFFFFF};
        sb_set  = 1'b1;
        sb_addr = 5'd9;
        wait_ready("clr_cycles", 31);
        model_zero();
        push_exp("post_clr_rd9", 32'h0);
        push_exp("post_clr_rd10", 32'h0);
        push_exp("post_clr_busy", 32'h0);
        #1;
        pop_check(rdp(0));
        pop_check(rdp(1));
        pop_check(32'(rd_busy));
        @(negedge clk);

        // Reset in the middle of a clear restarts the sweep
        clr_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_req = 1'b1;
        repeat (10) @(negedge clk);
        clr_req = 1'b0;
        rst_n   = 1'b0;
        #1;
        push_exp("midclr_rst_ready", 32'h0);
        push_exp("midclr_rst_busy", 32'h0);
        pop_check(32'(ready));
        pop_check(32'(rd_busy));
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("midclr_rst_cycles", 31);
        push_exp("final_rd", 32'h0);
        #1;
        pop_check(rdp(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
